// File: rtl/moore_seq_detector.sv
// Serial Moore detector for a runtime-loadable PAT_W-bit pattern, with a saturating match counter.
// Latency: one edge; state and match show the result of the bit sampled on that same edge.
// No backpressure: a bit is consumed on every edge with en=1, and all registers hold when en=0.
module moore_seq_detector #(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1011),
    localparam int              SW      = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             clr_cnt,
    output logic [SW-1:0]    state,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);

    // Active pattern. pat[PAT_W-1] is the first bit expected on the wire.
    logic [PAT_W-1:0] pat;

    // Matched-prefix length the transition starts from.
    logic [SW-1:0]    base;

    // Zero-extended pattern, used so prefix and suffix slices share one width.
    logic [PAT_W:0]   pat_ext;

    // prefix_base followed by x, right-aligned (the LSB is x).
    logic [PAT_W:0]   s_vec;

    // hit[j]: the top j pattern bits equal the last j bits of s_vec.
    logic [PAT_W:1]   hit;

    logic [SW-1:0]    nxt;
    logic             nxt_full;
    logic             cnt_sat;

    // Non-overlapping mode restarts from the empty prefix once a full match has been reported.
    always_comb begin
        base = state;
        if (state == SW'(PAT_W) && !overlap) begin
            base = '0;
        end
    end

    // Build s = prefix_base followed by x. prefix_base is the top "base" bits of the pattern.
    always_comb begin
        pat_ext = {1'b0, pat};
        s_vec   = ((pat_ext >> (SW'(PAT_W) - base)) << 1) | (PAT_W + 1)'(x);
    end

    // Evaluate every candidate length in parallel.
    // A candidate is only legal if s is at least j bits long (j <= base+1).
    always_comb begin
        hit = '0;
        for (int j = 1; j <= PAT_W; j++) begin
            hit[j] = (int'(base) >= j - 1) &&
                     ((s_vec & (((PAT_W + 1)'(1) << j) - (PAT_W + 1)'(1))) ==
                      (pat_ext >> (PAT_W - j)));
        end
    end

    // Pick the longest matching candidate, or 0 if none matches.
    always_comb begin
        nxt = '0;
        for (int j = 1; j <= PAT_W; j++) begin
            if (hit[j]) begin
                nxt = SW'(j);
            end
        end
    end

    assign nxt_full = (nxt == SW'(PAT_W));
    assign cnt_sat  = &match_cnt;

    // Register update, in priority order: reset, pattern load, counter clear, enabled sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat       <= PAT_RST;
            state     <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else if (load) begin
            // The sample on a load edge is dropped and any partial match is aborted.
            pat   <= pat_in;
            state <= '0;
            match <= 1'b0;
            if (clr_cnt) begin
                match_cnt <= '0;
            end
        end else begin
            if (en) begin
                state <= nxt;
                match <= nxt_full;
            end
            // A clear wins over an increment on the same edge.
            if (clr_cnt) begin
                match_cnt <= '0;
            end else if (en && nxt_full && !cnt_sat) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_moore_seq_detector.sv
// Bench for moore_seq_detector: directed scenarios plus random traffic checked against a reference model.
// The reference model keeps the received-bit history and searches it for the longest suffix that is also a pattern prefix.
// A second instance uses CNT_W=2 and pattern 1111 to exercise counter saturation.
module tb_moore_seq_detector;

    localparam int PAT_W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       x = 1'b0;
    logic       overlap = 1'b1;
    logic       load = 1'b0;
    logic [3:0] pat_in = 4'd0;
    logic       clr_cnt = 1'b0;

    logic [2:0] state;
    logic       match;
    logic [7:0] match_cnt;

    logic [2:0] state2;
    logic       match2;
    logic [1:0] match_cnt2;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit [3:0]   mpat;
    bit         hist[$];
    int         mstate;
    bit         mmatch;
    int         mcnt;

    moore_seq_detector dut (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .load(load),
        .pat_in(pat_in), .clr_cnt(clr_cnt),
        .state(state), .match(match), .match_cnt(match_cnt)
    );

    moore_seq_detector #(.PAT_W(4), .CNT_W(2), .PAT_RST(4'b1111)) dut2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .load(load),
        .pat_in(pat_in), .clr_cnt(clr_cnt),
        .state(state2), .match(match2), .match_cnt(match_cnt2)
    );

    always #5 clk = ~clk;

    // Advance one clock edge; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; x = 1'b0; load = 1'b0; clr_cnt = 1'b0;
        overlap = 1'b1; pat_in = 4'd0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Length of the longest history suffix that equals a pattern prefix, capped at PAT_W.
    function automatic int longest_suffix();
        int n;
        bit ok;
        n = hist.size();
        for (int j = (n < PAT_W ? n : PAT_W); j >= 1; j--) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (hist[n - j + i] != mpat[PAT_W - 1 - i]) ok = 1'b0;
            end
            if (ok) return j;
        end
        return 0;
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; x = 1'b1;
        step();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_match: got %0b expected 0", match); end
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", match_cnt); end
        checks++; if (match_cnt2 !== 2'd0) begin errors++; $display("FAIL reset_cnt2: got %0d expected 0", match_cnt2); end
        // With en low, the outputs must not move even though x toggles.
        rst = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x = ~x;
            step();
        end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_state: got %0d expected 0", state); end
    endtask

    task automatic test_overlap();
        bit xs[7]     = '{1, 0, 1, 1, 0, 1, 1};
        int exp_st[7] = '{1, 2, 3, 4, 2, 3, 4};
        do_reset();
        overlap = 1'b1; en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            x = xs[i];
            step();
            checks++; if (state !== 3'(exp_st[i])) begin errors++; $display("FAIL overlap_state edge %0d: got %0d expected %0d", i + 1, state, exp_st[i]); end
            checks++; if (match !== (exp_st[i] == 4)) begin errors++; $display("FAIL overlap_match edge %0d: got %0b expected %0b", i + 1, match, exp_st[i] == 4); end
        end
        checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL overlap_cnt: got %0d expected 2", match_cnt); end
        en = 1'b0;
    endtask

    task automatic test_nonoverlap();
        bit xs[7]     = '{1, 0, 1, 1, 0, 1, 1};
        int exp_st[7] = '{1, 2, 3, 4, 0, 1, 1};
        do_reset();
        overlap = 1'b0; en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            x = xs[i];
            step();
            checks++; if (state !== 3'(exp_st[i])) begin errors++; $display("FAIL nonoverlap_state edge %0d: got %0d expected %0d", i + 1, state, exp_st[i]); end
            checks++; if (match !== (exp_st[i] == 4)) begin errors++; $display("FAIL nonoverlap_match edge %0d: got %0b expected %0b", i + 1, match, exp_st[i] == 4); end
        end
        checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL nonoverlap_cnt: got %0d expected 1", match_cnt); end
        en = 1'b0;
    endtask

    task automatic test_enable();
        bit xs[4]     = '{1, 0, 1, 1};
        int exp_st[8] = '{1, 1, 2, 2, 3, 3, 4, 4};
        do_reset();
        overlap = 1'b1;
        for (int i = 0; i < 8; i++) begin
            en = (i % 2 == 0);
            // On disabled edges, drive the opposite of the next wanted bit to show it is ignored.
            x = en ? xs[i / 2] : ~xs[(i / 2 + 1) % 4];
            step();
            checks++; if (state !== 3'(exp_st[i])) begin errors++; $display("FAIL enable_state edge %0d: got %0d expected %0d", i + 1, state, exp_st[i]); end
        end
        checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL enable_cnt: got %0d expected 1", match_cnt); end
        en = 1'b0;
    endtask

    task automatic test_load();
        bit xs[6]     = '{1, 0, 1, 1, 0, 1};
        int exp_st[6] = '{1, 2, 3, 4, 4, 4};
        do_reset();
        overlap = 1'b1; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            x = xs[i];
            step();
        end
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL load_pre_state: got %0d expected 3", state); end
        // Load while a partial match is in progress and en=1, x=1.
        load = 1'b1; pat_in = 4'b1111; x = 1'b1;
        step();
        load = 1'b0;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL load_state: got %0d expected 0", state); end
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL load_match: got %0b expected 0", match); end
        checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL load_cnt: got %0d expected 1", match_cnt); end
        for (int i = 0; i < 6; i++) begin
            x = 1'b1;
            step();
            checks++; if (state !== 3'(exp_st[i])) begin errors++; $display("FAIL load_1111_state edge %0d: got %0d expected %0d", i + 1, state, exp_st[i]); end
        end
        checks++; if (match_cnt !== 8'd4) begin errors++; $display("FAIL load_1111_cnt: got %0d expected 4", match_cnt); end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        int exp_c;
        do_reset();
        overlap = 1'b1; en = 1'b1; x = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp_c = (i > 3) ? i - 3 : 0;
            if (exp_c > 3) exp_c = 3;
            checks++; if (match_cnt2 !== 2'(exp_c)) begin errors++; $display("FAIL sat_cnt edge %0d: got %0d expected %0d", i, match_cnt2, exp_c); end
        end
        // A clear on the same edge as a match wins over the increment.
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        checks++; if (match_cnt2 !== 2'd0) begin errors++; $display("FAIL clr_cnt: got %0d expected 0", match_cnt2); end
        checks++; if (match2 !== 1'b1) begin errors++; $display("FAIL clr_match: got %0b expected 1", match2); end
        step();
        checks++; if (match_cnt2 !== 2'd1) begin errors++; $display("FAIL post_clr_cnt: got %0d expected 1", match_cnt2); end
        en = 1'b0;
    endtask

    task automatic test_async_reset();
        bit xs[9]     = '{1, 1, 1, 1, 1, 0, 1, 1, 1};
        bit ys[4]     = '{1, 0, 1, 1};
        int exp_st[4] = '{1, 2, 3, 4};
        do_reset();
        load = 1'b1; pat_in = 4'b1111;
        step();
        load = 1'b0;
        overlap = 1'b1; en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            x = xs[i];
            step();
        end
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL areset_pre_state: got %0d expected 3", state); end
        checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL areset_pre_cnt: got %0d expected 2", match_cnt); end
        // Assert reset between edges; the outputs must clear before the next edge.
        rst = 1'b1;
        #2;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL areset_state: got %0d expected 0", state); end
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL areset_match: got %0b expected 0", match); end
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL areset_cnt: got %0d expected 0", match_cnt); end
        #1;
        rst = 1'b0;
        // Pattern must be back to 1011.
        for (int i = 0; i < 4; i++) begin
            x = ys[i];
            step();
            checks++; if (state !== 3'(exp_st[i])) begin errors++; $display("FAIL areset_pat_state edge %0d: got %0d expected %0d", i + 1, state, exp_st[i]); end
        end
        en = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        mpat = 4'b1011; hist.delete(); mstate = 0; mmatch = 1'b0; mcnt = 0;
        for (int c = 0; c < 800; c++) begin
            en      = ($urandom_range(0, 3) != 0);
            x       = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) overlap = ~overlap;
            load    = ($urandom_range(0, 39) == 0);
            pat_in  = 4'($urandom_range(0, 15));
            clr_cnt = ($urandom_range(0, 49) == 0);
            if (load) begin
                mpat = pat_in; hist.delete(); mstate = 0; mmatch = 1'b0;
                if (clr_cnt) mcnt = 0;
            end else begin
                if (en) begin
                    if (mstate == PAT_W && !overlap) hist.delete();
                    hist.push_back(x);
                    while (hist.size() > PAT_W) void'(hist.pop_front());
                    mstate = longest_suffix();
                    mmatch = (mstate == PAT_W);
                end
                if (clr_cnt) mcnt = 0;
                else if (en && mstate == PAT_W && mcnt < 255) mcnt++;
            end
            step();
            checks++; if (state !== 3'(mstate)) begin errors++; $display("FAIL rand_state cycle %0d: got %0d expected %0d", c, state, mstate); end
            checks++; if (match !== mmatch) begin errors++; $display("FAIL rand_match cycle %0d: got %0b expected %0b", c, match, mmatch); end
            checks++; if (match_cnt !== 8'(mcnt)) begin errors++; $display("FAIL rand_cnt cycle %0d: got %0d expected %0d", c, match_cnt, mcnt); end
        end
        en = 1'b0; load = 1'b0; clr_cnt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_enable();
        test_load();
        test_saturate();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/moore_seq_detector.md
# moore_seq_detector

Parametrised Moore-type serial sequence detector. It is the generalised successor to the team's fixed 3-bit-state Moore FSM core. It runs a runtime-loadable pattern of PAT_W bits, selectable overlapping or non-overlapping detection, a sample-enable strobe, and a saturating match counter. It sits behind the top-level pin wrapper: ui_in bits feed x, en and load, and the state, match and count outputs drive uo_out.

## Interface

Parameters:
- PAT_W, default 4: pattern length in bits; legal range 2..8.
- CNT_W, default 8: match counter width; legal range 1..16.
- PAT_RST, default 4'b1011 (PAT_W bits wide): pattern register value after reset.
- SW is derived, not overridable: SW = $clog2(PAT_W+1), the state width (3 for the defaults).

Ports:
- clk  in  1  single clock; all flops rise-edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample strobe; x is consumed only on edges where en=1.
- x  in  1  serial data bit.
- overlap  in  1  1 selects overlapping detection; 0 selects non-overlapping.
- load  in  1  synchronous pattern load strobe.
- pat_in  in  PAT_W  new pattern, taken on load.
- clr_cnt  in  1  synchronous counter clear.
- state  out  SW  current state k, the number of pattern bits currently matched (0..PAT_W).
- match  out  1  Moore output; 1 exactly when state == PAT_W.
- match_cnt  out  CNT_W  count of entries into state PAT_W; saturating.

## Operation

- Bit order: pat[PAT_W-1] is the first bit expected. prefix_k means the top k bits of pat.
- State k is the length of the longest suffix of the bits received since the last reset or load that equals prefix_k, capped at PAT_W.
- Next-state rule, from state k with input x, where base = k (or base = 0 when k == PAT_W and overlap=0):
  - Consider the string s = prefix_base followed by x.
  - next = the largest j in 1..min(base+1, PAT_W) such that the top j bits of pat equal the last j bits of s.
  - next = 0 if no such j exists.
- All j candidates are evaluated combinationally in parallel; this is a KMP-equivalent transition with no lookup table.
- match is a flop updated on the same edge as state, with value (next == PAT_W). It is never a combinational decode.
- Counter: match_cnt increments on each edge where en=1 and next == PAT_W.
  - This includes PAT_W→PAT_W re-entry in overlap mode, for example a self-overlapping pattern such as 1111.
  - The counter saturates at 2^CNT_W−1 and does not wrap.
- Priority within one edge, highest first:
  1. rst: state=0, match=0, match_cnt=0, pat=PAT_RST.
  2. load: pat ← pat_in, state ← 0, match ← 0. The x sample is discarded and no increment occurs. match_cnt is not cleared unless clr_cnt is also 1.
  3. clr_cnt: match_cnt ← 0. This wins over a same-edge increment. The state update still proceeds.
  4. en: state, match and match_cnt update per the rules above.
  5. Otherwise all registers hold.
- Changing overlap takes effect on the next en edge. It never alters the state directly.

## Timing

- Reset asserts asynchronously. Deassertion must be synchronous to clk, which the wrapper guarantees. Reset values: state=0, match=0, match_cnt=0.
- Latency is one cycle. The edge that samples the final pattern bit raises match and state=PAT_W; both are visible immediately after that edge.
- match_cnt reflects a match on the same edge as match.
- With en held low, outputs are static indefinitely.
- A load issued mid-sequence aborts any partial match on that edge. Detection restarts from the next en edge, using the new pattern.

## Test plan

1. Defaults (PAT_W=4, pattern 1011), overlap=1, en=1, x = 1,0,1,1,0,1,1 → state after each edge 1,2,3,4,2,3,4; match high after edges 4 and 7; match_cnt=2.
2. Same stimulus with overlap=0 → state 1,2,3,4,0,1,1; match only after edge 4; match_cnt=1.
3. Pattern 1011, en toggled 1,0,1,0,... with x presented only on en=1 edges as 1,0,1,1 → state advances only on en edges and reaches 4 after the 4th enabled edge; x values on en=0 edges are ignored.
4. Load pat_in=1111 at state 3 while en=1 and x=1 → state=0, match=0, match_cnt unchanged. Then x = 1 ×6 with overlap=1 → match from the 4th bit onward; match_cnt +3.
5. CNT_W=2, pattern 1111, overlap=1, x=1 for 10 edges → match_cnt saturates at 3. Then clr_cnt=1 on the same edge as another match → match_cnt=0, match=1.
6. Assert rst asynchronously mid-sequence (between edges, at state 3) → state, match and match_cnt read 0 before the next edge, and pattern is back to 1011.
